// File: rtl/hps_gp_bridge.sv
// rtl/hps_gp_bridge.sv - HPS GP register pair to CPC byte register bus command bridge
//
// Purpose: takes toggle-flagged commands from the HPS gp_out word, runs each one
// as a single read or write on the byte-wide FPGA register bus, and reports status
// and read data on gp_in. With GP_BRIDGE_EVT_FIFO_EN defined, an event FIFO is
// present and address 0xFF is reserved: a read pops one byte, a write clears overflow.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   gp_out[31:0]        HPS command word (asynchronous to clk)
//   gp_in[31:0]         HPS status word {ack_tog, ovf, err, level[4:0], addr, 8'h0, rdata}
//   bus_addr, bus_wdata register address / write data, held from strobe to completion
//   bus_we, bus_re      one-cycle write / read strobes
//   bus_rdata, bus_ack  read data and completion from the register bus
//   evt_valid, evt_data event byte push
//   evt_ready           event FIFO not full

module hps_gp_bridge #(
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] gp_out,
  output logic [31:0] gp_in,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  input  logic        evt_valid,
  input  logic [7:0]  evt_data,
  output logic        evt_ready
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] gp_meta, gp_sync;
  logic        tog_prev;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [7:0]  cnt;
  logic        ack_tog, err_q;
  logic [7:0]  last_addr, rdata_q;
  logic        ovf;
  logic [4:0]  level;
  logic [7:0]  pop_data;
  logic        start, is_rsv, new_we;
  logic [7:0]  new_addr;
  logic        fin, fin_err;
  logic [7:0]  fin_rdata, fin_addr;
  logic        unused_gp;

  // Synchronizer is deliberately not reset so tog_prev can follow it during reset.
  always_ff @(posedge clk) begin
    gp_meta <= gp_out;
    gp_sync <= gp_meta;
  end

  assign unused_gp = ^{gp_sync[29:24], gp_sync[15:8]};
  assign start     = (state == S_IDLE) && (gp_sync[31] != tog_prev);
  assign new_we    = gp_sync[30];
  assign new_addr  = gp_sync[23:16];

  assign gp_in = {ack_tog, ovf, err_q, level, last_addr, 8'h00, rdata_q};

  always_comb begin
    state_nxt = state;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = 8'h00;
    fin_addr  = cmd_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          fin_addr = new_addr;
          if (is_rsv) begin
            fin       = 1'b1;
            fin_rdata = new_we ? 8'h00 : pop_data;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_STROBE;
          end
        end
      end
      S_STROBE: begin
        bus_we = cmd_we;
        bus_re = ~cmd_we;
        if (bus_ack) begin
          fin       = 1'b1;
          fin_rdata = cmd_we ? 8'h00 : bus_rdata;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          fin       = 1'b1;
          fin_rdata = cmd_we ? 8'h00 : bus_rdata;
          state_nxt = S_DONE;
        end else if (cnt + 8'd1 == TO) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = 8'hEE;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // gp_in result fields load on entry to DONE so they are visible during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tog_prev  <= gp_sync[31];
      cmd_we    <= 1'b0;
      cmd_addr  <= 8'h00;
      bus_addr  <= 8'h00;
      bus_wdata <= 8'h00;
      cnt       <= 8'h00;
      ack_tog   <= 1'b0;
      err_q     <= 1'b0;
      last_addr <= 8'h00;
      rdata_q   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (start) begin
        tog_prev <= gp_sync[31];
        cmd_we   <= new_we;
        cmd_addr <= new_addr;
        if (!is_rsv) begin
          bus_addr  <= new_addr;
          bus_wdata <= gp_sync[7:0];
        end
      end
      if (state == S_STROBE)
        cnt <= 8'h00;
      else if (state == S_WAIT)
        cnt <= cnt + 8'd1;
      if (fin) begin
        ack_tog   <= ~ack_tog;
        err_q     <= fin_err;
        last_addr <= fin_addr;
        rdata_q   <= fin_rdata;
      end
    end
  end

`ifdef GP_BRIDGE_EVT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push, pop_req, ovf_clr;

  assign is_rsv   = (new_addr == 8'hFF);
  assign pop_req  = start && is_rsv && !new_we;
  assign ovf_clr  = start && is_rsv && new_we;
  assign full     = (level == 5'(FIFO_DEPTH));
  assign pop      = pop_req && (level != 5'd0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = evt_valid && (!full || pop);
  assign evt_ready = !full;
  assign pop_data = (level != 5'd0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= evt_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (ovf_clr) ovf <= 1'b0;
      if (evt_valid && !push) ovf <= 1'b1;
    end
  end
`else
  localparam int unused_depth = FIFO_DEPTH;
  logic unused_evt;

  assign unused_evt = ^{evt_valid, evt_data, unused_depth[0]};
  assign is_rsv     = 1'b0;
  assign pop_data   = 8'h00;
  assign level      = 5'd0;
  assign ovf        = 1'b0;
  assign evt_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_hps_gp_bridge.sv
// tb/tb_hps_gp_bridge.sv - self-checking bench for hps_gp_bridge
`timescale 1ns/1ps

module tb_hps_gp_bridge;

  localparam int TIMEOUT = 255;
  localparam int DEPTH   = 16;
`ifdef GP_BRIDGE_EVT_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] gp_out = '0;
  logic [31:0] gp_in;
  logic [7:0]  bus_addr, bus_wdata;
  logic        bus_we, bus_re;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        evt_valid = 1'b0;
  logic [7:0]  evt_data = '0;
  logic        evt_ready;

  hps_gp_bridge #(.TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .gp_out(gp_out), .gp_in(gp_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: gp_in fields, FIFO contents, and one scheduled result/strobe.
  bit         chk_on = 1'b0;
  bit         tog = 1'b0;
  bit         exp_tog, exp_err, ovf_m;
  logic [7:0] exp_addr, exp_rd;
  logic [7:0] fq[$];
  bit         pend_v;
  int         pend_cyc, pend_kind;
  bit         pend_err;
  logic [7:0] pend_addr, pend_rd;
  bit         stb_v;
  int         stb_cyc;
  bit         stb_we;
  logic [7:0] stb_addr, stb_wd;
  int         push_cyc_q[$];
  logic [7:0] push_dat_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_gp_in();
    logic [4:0] lvl;
    lvl = FIFO_EN ? 5'(fq.size()) : 5'd0;
    return {exp_tog, FIFO_EN ? ovf_m : 1'b0, exp_err, lvl, exp_addr, 8'h00, exp_rd};
  endfunction

  always @(negedge clk) begin : cmp
    logic [7:0] b;
    bit stb_now;
    if (chk_on) begin
      if (pend_v && cyc == pend_cyc) begin
        pend_v   = 1'b0;
        exp_tog  = ~exp_tog;
        exp_addr = pend_addr;
        exp_err  = pend_err;
        if (pend_kind == 0) begin
          exp_rd = pend_rd;
        end else if (pend_kind == 1) begin
          if (fq.size() > 0) exp_rd = fq.pop_front();
          else exp_rd = 8'h00;
        end else begin
          exp_rd = 8'h00;
          ovf_m  = 1'b0;
        end
      end
      while (push_cyc_q.size() > 0 && push_cyc_q[0] == cyc) begin
        void'(push_cyc_q.pop_front());
        b = push_dat_q.pop_front();
        if (FIFO_EN) begin
          if (fq.size() < DEPTH) fq.push_back(b);
          else ovf_m = 1'b1;
        end
      end
      chk("gp_in", gp_in, model_gp_in());
      stb_now = stb_v && (cyc == stb_cyc);
      chk("bus_we", {31'd0, bus_we}, {31'd0, stb_now && stb_we});
      chk("bus_re", {31'd0, bus_re}, {31'd0, stb_now && !stb_we});
      if (stb_now) begin
        chk("bus_addr", {24'd0, bus_addr}, {24'd0, stb_addr});
        if (stb_we) chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, stb_wd});
      end
      chk("evt_ready", {31'd0, evt_ready}, {31'd0, FIFO_EN && (fq.size() < DEPTH)});
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    chk_on = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gp_in", gp_in, 32'h0);
    chk("reset strobes", {30'd0, bus_we, bus_re}, 32'h0);
    chk("reset bus_addr", {16'd0, bus_addr, bus_wdata}, 32'h0);
    chk("reset evt_ready", {31'd0, evt_ready}, {31'd0, FIFO_EN});
    pend_v = 0; stb_v = 0;
    exp_tog = 0; exp_err = 0; ovf_m = 0; exp_addr = 0; exp_rd = 0;
    fq.delete(); push_cyc_q.delete(); push_dat_q.delete();
    reset  = 1'b0;
    chk_on = 1'b1;
  endtask

  // HPS command: payload with old toggle, then the same payload with toggle flipped.
  // ack_k < 0 means the bus never acknowledges.
  task automatic cmd(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                     input int ack_k, input logic [7:0] rd);
    int n;
    bit rsv;
    rsv = FIFO_EN && (addr == 8'hFF);
    gp_out = {tog, we, 6'd0, addr, 8'd0, wd};
    repeat (3) begin @(posedge clk); #1; end
    tog = ~tog;
    gp_out[31] = tog;
    n = cyc + 2;
    pend_addr = addr;
    if (rsv) begin
      pend_kind = we ? 2 : 1;
      pend_err  = 1'b0;
      pend_rd   = 8'h00;
      pend_cyc  = n + 1;
      pend_v    = 1'b1;
      wait_cyc(pend_cyc + 1);
    end else begin
      stb_we = we; stb_addr = addr; stb_wd = wd; stb_cyc = n + 1; stb_v = 1'b1;
      pend_kind = 0;
      if (ack_k >= 0) begin
        pend_err = 1'b0;
        pend_rd  = we ? 8'h00 : rd;
        pend_cyc = n + 2 + ack_k;
        pend_v   = 1'b1;
        wait_cyc(n + 1 + ack_k);
        bus_ack = 1'b1; bus_rdata = rd;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 8'h00;
      end else begin
        pend_err = 1'b1;
        pend_rd  = 8'hEE;
        pend_cyc = n + 2 + TIMEOUT;
        pend_v   = 1'b1;
      end
      wait_cyc(pend_cyc + 1);
      stb_v = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    evt_valid = 1'b1;
    evt_data  = b;
    push_cyc_q.push_back(cyc + 1);
    push_dat_q.push_back(b);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (2) begin @(posedge clk); #1; end

    cmd(1'b1, 8'h12, 8'hA5, 0, 8'h00);
    chk("write result", gp_in, 32'h8012_0000);

    cmd(1'b0, 8'h34, 8'h00, 3, 8'h5C);
    chk("read result", gp_in, 32'h0034_005C);

    cmd(1'b0, 8'h01, 8'h00, -1, 8'h00);
    chk("timeout result", gp_in, 32'hA001_00EE);
    bus_ack = 1'b1; bus_rdata = 8'h99;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 8'h00;
    repeat (4) begin @(posedge clk); #1; end
    chk("late ack ignored", gp_in, 32'hA001_00EE);

    push_byte(8'h11);
    push_byte(8'h22);
    evt_valid = 1'b0;
    @(posedge clk); #1;
    chk("level after 2 pushes", {27'd0, gp_in[28:24]}, FIFO_EN ? 32'd2 : 32'd0);

    cmd(1'b0, 8'hFF, 8'h00, 0, 8'h3C);
    chk("0xFF read 1", gp_in, FIFO_EN ? 32'h01FF_0011 : 32'h00FF_003C);
    cmd(1'b0, 8'hFF, 8'h00, 0, 8'h3C);
    chk("0xFF read 2", gp_in, FIFO_EN ? 32'h80FF_0022 : 32'h80FF_003C);
    cmd(1'b0, 8'hFF, 8'h00, 0, 8'h3C);
    chk("0xFF read 3", gp_in, FIFO_EN ? 32'h00FF_0000 : 32'h00FF_003C);

    for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i));
    evt_valid = 1'b0;
    @(posedge clk); #1;
    chk("full evt_ready", {31'd0, evt_ready}, 32'd0);
    chk("overflow flag", {31'd0, gp_in[30]}, {31'd0, FIFO_EN});
    chk("full level", {27'd0, gp_in[28:24]}, FIFO_EN ? 32'd16 : 32'd0);

    cmd(1'b1, 8'hFF, 8'h00, 0, 8'h00);
    chk("overflow clear", gp_in, FIFO_EN ? 32'h90FF_0000 : 32'h80FF_0000);

    cmd(1'b1, 8'h7E, 8'h55, 1, 8'h00);
    chk("write 7E", gp_in, FIFO_EN ? 32'h107E_0000 : 32'h007E_0000);

    // Reset in the middle of a read that is waiting for an ack.
    gp_out = {tog, 1'b0, 6'd0, 8'h40, 16'h0000};
    repeat (3) begin @(posedge clk); #1; end
    tog = ~tog;
    gp_out[31] = tog;
    n = cyc + 2;
    stb_we = 1'b0; stb_addr = 8'h40; stb_wd = 8'h00; stb_cyc = n + 1; stb_v = 1'b1;
    wait_cyc(n + 6);
    do_reset();
    repeat (20) begin @(posedge clk); #1; end
    chk("no command after reset", gp_in, 32'h0);

    cmd(1'b1, 8'h21, 8'h99, 2, 8'h00);
    chk("command after reset", gp_in, 32'h8021_0000);

    repeat (3) begin @(posedge clk); #1; end
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
